// File: rtl/inst_encoder_pkg.sv
// Shared types and constants for the RV32I instruction encoder.
package inst_encoder_pkg;

    // Format codes carried on i_fmt; 6 and 7 have no member and are rejected.
    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_RANGE    = 2'd1,
        ERR_MISALIGN = 2'd2,
        ERR_BADFMT   = 2'd3
    } err_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    // addi x0, x0, 0 -- substituted for any word that failed its checks.
    localparam logic [31:0] INST_NOP = 32'h00000013;

endpackage

// File: rtl/inst_encoder_pack.sv
// Combinational RV32I bit placement of fields and immediate into one word.
module inst_pack
    import inst_encoder_pkg::*;
(
    input  logic [2:0]  i_fmt,
    input  logic [6:0]  i_opcode,
    input  logic [2:0]  i_funct3,
    input  logic [6:0]  i_funct7,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [31:0] i_imm,
    output logic [31:0] o_inst
);

    // Select the standard field layout for the requested format.
    always_comb begin
        o_inst = INST_NOP;
        case (i_fmt)
            FMT_R: o_inst = {i_funct7, i_rs2, i_rs1, i_funct3, i_rd, i_opcode};
            FMT_I: o_inst = {i_imm[11:0], i_rs1, i_funct3, i_rd, i_opcode};
            FMT_S: o_inst = {i_imm[11:5], i_rs2, i_rs1, i_funct3, i_imm[4:0], i_opcode};
            FMT_B: o_inst = {i_imm[12], i_imm[10:5], i_rs2, i_rs1, i_funct3,
                             i_imm[4:1], i_imm[11], i_opcode};
            FMT_U: o_inst = {i_imm[31:12], i_rd, i_opcode};
            FMT_J: o_inst = {i_imm[20], i_imm[10:1], i_imm[11], i_imm[19:12],
                             i_rd, i_opcode};
            default: o_inst = INST_NOP;
        endcase
    end

endmodule

// File: rtl/inst_encoder.sv
// Two-stage valid/ready RV32I encoder: S1 registers fields and the error
// code, S2 holds the assembled word. Counts error-free words delivered.
module inst_encoder
    import inst_encoder_pkg::*;
#(
    parameter int N = 32
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [2:0]   i_fmt,
    input  logic [6:0]   i_opcode,
    input  logic [2:0]   i_funct3,
    input  logic [6:0]   i_funct7,
    input  logic [4:0]   i_rd,
    input  logic [4:0]   i_rs1,
    input  logic [4:0]   i_rs2,
    input  logic [N-1:0] i_imm,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [31:0]  o_inst,
    output logic         o_err,
    output logic [1:0]   o_err_code,
    output logic [15:0]  o_count
);

    logic        s1_valid_q, s1_valid_d;
    logic [2:0]  s1_fmt_q, s1_fmt_d;
    logic [6:0]  s1_opcode_q, s1_opcode_d;
    logic [2:0]  s1_funct3_q, s1_funct3_d;
    logic [6:0]  s1_funct7_q, s1_funct7_d;
    logic [4:0]  s1_rd_q, s1_rd_d;
    logic [4:0]  s1_rs1_q, s1_rs1_d;
    logic [4:0]  s1_rs2_q, s1_rs2_d;
    logic [31:0] s1_imm_q, s1_imm_d;
    err_e        s1_err_q, s1_err_d;

    logic        s2_valid_q, s2_valid_d;
    logic [31:0] s2_inst_q, s2_inst_d;
    err_e        s2_err_q, s2_err_d;
    logic [15:0] count_q, count_d;

    logic        s2_adv, s1_adv, in_hs, out_hs;
    logic        hi11_same, hi12_same, hi20_same;
    logic [31:0] imm_ext;
    logic [31:0] packed_inst;
    err_e        err_in;

    // Sign-extend (or truncate) the immediate to the 32-bit instruction domain.
    assign imm_ext = 32'(signed'(i_imm));

    // Handshake and stage-advance conditions; o_ready never looks at i_valid.
    always_comb begin
        s2_adv  = !s2_valid_q || i_ready;
        s1_adv  = s1_valid_q && s2_adv;
        o_ready = !s1_valid_q || s1_adv;
        in_hs   = i_valid && o_ready;
        out_hs  = s2_valid_q && i_ready;
    end

    // Immediate range/alignment checks, priority bad format > misaligned > range.
    always_comb begin
        hi11_same = (&i_imm[N-1:11]) || !(|i_imm[N-1:11]);
        hi12_same = (&i_imm[N-1:12]) || !(|i_imm[N-1:12]);
        hi20_same = (&i_imm[N-1:20]) || !(|i_imm[N-1:20]);
        err_in    = ERR_NONE;
        case (i_fmt)
            FMT_R: err_in = ERR_NONE;
            FMT_I, FMT_S: begin
                if (!hi11_same) err_in = ERR_RANGE;
            end
            FMT_B: begin
                if (i_imm[0])        err_in = ERR_MISALIGN;
                else if (!hi12_same) err_in = ERR_RANGE;
            end
            FMT_U: begin
                if (i_imm[11:0] != 12'd0) err_in = ERR_RANGE;
            end
            FMT_J: begin
                if (i_imm[0])        err_in = ERR_MISALIGN;
                else if (!hi20_same) err_in = ERR_RANGE;
            end
            default: err_in = ERR_BADFMT;
        endcase
    end

    // S1 loads on an input handshake and empties when it moves into S2.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_fmt_d    = s1_fmt_q;
        s1_opcode_d = s1_opcode_q;
        s1_funct3_d = s1_funct3_q;
        s1_funct7_d = s1_funct7_q;
        s1_rd_d     = s1_rd_q;
        s1_rs1_d    = s1_rs1_q;
        s1_rs2_d    = s1_rs2_q;
        s1_imm_d    = s1_imm_q;
        s1_err_d    = s1_err_q;
        if (s1_adv) s1_valid_d = 1'b0;
        if (in_hs) begin
            s1_valid_d  = 1'b1;
            s1_fmt_d    = i_fmt;
            s1_opcode_d = i_opcode;
            s1_funct3_d = i_funct3;
            s1_funct7_d = i_funct7;
            s1_rd_d     = i_rd;
            s1_rs1_d    = i_rs1;
            s1_rs2_d    = i_rs2;
            s1_imm_d    = imm_ext;
            s1_err_d    = err_in;
        end
    end

    inst_pack u_pack (
        .i_fmt    (s1_fmt_q),
        .i_opcode (s1_opcode_q),
        .i_funct3 (s1_funct3_q),
        .i_funct7 (s1_funct7_q),
        .i_rd     (s1_rd_q),
        .i_rs1    (s1_rs1_q),
        .i_rs2    (s1_rs2_q),
        .i_imm    (s1_imm_q),
        .o_inst   (packed_inst)
    );

    // S2 takes the assembled word (or NOP on error) whenever it may advance.
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_inst_d  = s2_inst_q;
        s2_err_d   = s2_err_q;
        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_inst_d = (s1_err_q == ERR_NONE) ? packed_inst : INST_NOP;
                s2_err_d  = s1_err_q;
            end
        end
    end

    // Saturating count of error-free words accepted downstream.
    always_comb begin
        count_d = count_q;
        if (out_hs && (s2_err_q == ERR_NONE) && (count_q != 16'hFFFF))
            count_d = count_q + 16'd1;
    end

    // State registers, asynchronously cleared; in-flight requests are dropped.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_valid_q  <= 1'b0;
            s1_fmt_q    <= 3'd0;
            s1_opcode_q <= 7'd0;
            s1_funct3_q <= 3'd0;
            s1_funct7_q <= 7'd0;
            s1_rd_q     <= 5'd0;
            s1_rs1_q    <= 5'd0;
            s1_rs2_q    <= 5'd0;
            s1_imm_q    <= 32'd0;
            s1_err_q    <= ERR_NONE;
            s2_valid_q  <= 1'b0;
            s2_inst_q   <= 32'd0;
            s2_err_q    <= ERR_NONE;
            count_q     <= 16'd0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_fmt_q    <= s1_fmt_d;
            s1_opcode_q <= s1_opcode_d;
            s1_funct3_q <= s1_funct3_d;
            s1_funct7_q <= s1_funct7_d;
            s1_rd_q     <= s1_rd_d;
            s1_rs1_q    <= s1_rs1_d;
            s1_rs2_q    <= s1_rs2_d;
            s1_imm_q    <= s1_imm_d;
            s1_err_q    <= s1_err_d;
            s2_valid_q  <= s2_valid_d;
            s2_inst_q   <= s2_inst_d;
            s2_err_q    <= s2_err_d;
            count_q     <= count_d;
        end
    end

    assign o_valid    = s2_valid_q;
    assign o_inst     = s2_inst_q;
    assign o_err      = (s2_err_q != ERR_NONE);
    assign o_err_code = s2_err_q;
    assign o_count    = count_q;

endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameter N, default 32, giving the width of i_imm.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state is updated on the rising edge.
REQ-003 SHALL have port i_rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have port i_valid, input, 1 bit: an encode request is present.
REQ-005 SHALL have port o_ready, output, 1 bit: the block accepts the request this cycle.
REQ-006 SHALL have port i_fmt, input, 3 bits: format code, R=0, I=1, S=2, B=3, U=4, J=5; values 6 and 7 are invalid.
REQ-007 SHALL have ports i_opcode (7 bits), i_funct3 (3 bits) and i_funct7 (7 bits), all inputs: raw instruction fields.
REQ-008 SHALL have ports i_rd, i_rs1 and i_rs2, all inputs, 5 bits each: register indices.
REQ-009 SHALL have port i_imm, input, N bits: the signed byte-offset or immediate value.
REQ-010 SHALL have port o_valid, output, 1 bit: an encoded word is present.
REQ-011 SHALL have port i_ready, input, 1 bit: downstream accepts the word.
REQ-012 SHALL have port o_inst, output, 32 bits: the encoded instruction word.
REQ-013 SHALL have ports o_err (1 bit) and o_err_code (2 bits), outputs: the error code is 0 none, 1 range, 2 misaligned, 3 bad format.
REQ-014 SHALL have port o_count, output, 16 bits: count of error-free words delivered.

Function
REQ-015 SHALL treat a handshake as valid&&ready on both the input and output sides, and SHALL neither lose nor duplicate requests.
REQ-016 SHALL implement two register stages:
- S1 captures the fields and computes the error code.
- S2 holds the assembled o_inst.
- Latency with i_ready held high is 2 cycles from input handshake to o_valid; throughput is 1 word/cycle.
REQ-017 SHALL advance S2 when !s2_valid || i_ready, and advance S1 into S2 when s1_valid and S2 advances.
REQ-018 SHALL drive o_ready = !s1_valid || (S1 advancing) as a combinational function of state and i_ready, with no dependency on i_valid.
REQ-019 SHALL assemble each format in standard RV32I bit placement: R uses funct7/rs2/rs1/funct3/rd/opcode; I uses imm[11:0]; S splits imm[11:5]/imm[4:0]; B uses imm[12|10:5|4:1|11]; U uses imm[31:12]; J uses imm[20|10:1|11|19:12].
REQ-020 SHALL check the immediate as follows:
- I/S: i_imm[N-1:11] are all equal.
- B: i_imm[N-1:12] are all equal, and i_imm[0]=0.
- J: i_imm[N-1:20] are all equal, and i_imm[0]=0.
- U: i_imm[11:0]=0, which is a range error otherwise.
- R: i_imm is ignored.
REQ-021 SHALL apply error priority bad format > misaligned > range.
REQ-022 SHALL, on any error, output o_inst=32'h00000013 with o_err=1 and the matching o_err_code; o_err and o_err_code travel with their word.
REQ-023 SHALL increment o_count on each output handshake with o_err=0, saturating at 16'hFFFF.
REQ-024 SHALL hold o_inst, o_err and o_err_code stable while o_valid && !i_ready.
REQ-025 SHALL accept a simultaneous input and output handshake in the same cycle with both stages full, with no bubble inserted.

Reset
REQ-026 SHALL, on i_rst assertion at any time including mid-transfer, asynchronously clear:
- both stage valids;
- o_inst to 0, o_err to 0 and o_err_code to 0;
- o_count to 0.
In-flight requests are discarded.
REQ-027 SHALL hold o_ready=1 and o_valid=0 while reset is asserted and in the first cycle after release.

Structure
REQ-028 SHALL place in a shared package:
- the format enum;
- the error-code enum;
- opcode constants (OP, OP-IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR);
- the NOP constant 32'h00000013.
REQ-029 SHALL contain one combinational sub-module, inst_pack, mapping fmt/fields/imm to a 32-bit word; the range check and the pipeline stay in inst_encoder.

Verification
REQ-030 The bench SHALL drive I: fmt=1, opcode=0010011, rd=1, rs1=0, f3=0, imm=-1, and SHALL require o_inst=32'hFFF00093, o_err=0, with o_valid asserted 2 cycles later.
REQ-031 The bench SHALL drive B: fmt=3, opcode=1100011, rs1=rs2=0, imm=8, and SHALL require 32'h00000463; then J: rd=1, imm=32'h800, and SHALL require 32'h001000EF.
REQ-032 The bench SHALL drive U: fmt=4, opcode=0110111, rd=5, imm=32'h12345000, and SHALL require 32'h123452B7.
REQ-033 The bench SHALL cover the error cases and SHALL require o_count unchanged in each:
- B with imm=3 -> code 2, o_inst=32'h00000013.
- S with imm=2048 -> code 1.
- fmt=7 -> code 3.
REQ-034 The bench SHALL, with i_ready=0 for 4 cycles while streaming 3 requests, require:
- o_ready falls after 2 accepts;
- o_inst stays stable;
- on release, all words emerge in order with none lost.
REQ-035 The bench SHALL assert i_rst mid-stream with both stages full and SHALL require o_valid=0 and o_count=0 immediately, and o_ready=1.
